// File: rtl/rf_read_arbiter.sv
// ============================================================================
// Module   : rf_read_arbiter
// Purpose  : Round-robin arbiter sharing one register-file read port among
//            NREQ requesters; issues the mux select, captures the read data
//            and returns it to the winner with a one-hot valid pulse.
//            Optional macro ZERO_REG_EN makes address 31 read as zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_read_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic                     stall,
  output logic [NREQ-1:0]          gnt,
  output logic [ADDR_W-1:0]        rf_sel,
  input  logic [DATA_W-1:0]        rf_data,
  output logic [DATA_W-1:0]        rdata,
  output logic [NREQ-1:0]          rvalid
);

  localparam int c_PTR_W = $clog2(NREQ);
`ifdef ZERO_REG_EN
  localparam logic [ADDR_W-1:0] c_ZERO_ADDR = ADDR_W'(31);
`endif

  logic [c_PTR_W-1:0] r_ptr;
  logic [NREQ-1:0]    r_gnt;
  logic [NREQ-1:0]    r_rvalid;
  logic [ADDR_W-1:0]  r_sel;
  logic [DATA_W-1:0]  r_rdata;

  logic [NREQ-1:0]    w_elig;
  logic               w_hi_found;
  logic               w_lo_found;
  logic [c_PTR_W-1:0] w_hi_idx;
  logic [c_PTR_W-1:0] w_lo_idx;
  logic [c_PTR_W-1:0] w_win_idx;
  logic [c_PTR_W-1:0] w_next_ptr;
  logic               w_grant;
  logic [NREQ-1:0]    w_win_onehot;
  logic [ADDR_W-1:0]  w_win_addr;
  logic [DATA_W-1:0]  w_cap_data;

  // Two-pass search: lowest eligible index at/above the pointer wins,
  // otherwise wrap around to the lowest eligible index overall.
  always_comb begin
    w_elig     = req & ~r_gnt;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = c_PTR_W'(i);
        if (c_PTR_W'(i) >= r_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = c_PTR_W'(i);
        end
      end
    end
    w_win_idx    = w_hi_found ? w_hi_idx : w_lo_idx;
    w_grant      = w_lo_found && !stall;
    w_win_onehot = NREQ'(1) << w_win_idx;
    w_win_addr   = addr[w_win_idx*ADDR_W +: ADDR_W];
    w_next_ptr   = (w_win_idx == c_PTR_W'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;
  end

  always_comb begin
`ifdef ZERO_REG_EN
    w_cap_data = (r_sel == c_ZERO_ADDR) ? '0 : rf_data;
`else
    w_cap_data = rf_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_sel    <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= r_gnt;
      if (|r_gnt) begin
        r_rdata <= w_cap_data;
      end
      if (w_grant) begin
        r_gnt <= w_win_onehot;
        r_sel <= w_win_addr;
        r_ptr <= w_next_ptr;
      end else begin
        r_gnt <= '0;
      end
    end
  end

  assign gnt    = r_gnt;
  assign rf_sel = r_sel;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;

endmodule

`default_nettype wire

// File: tb/tb_rf_read_arbiter.sv
// Self-checking bench for rf_read_arbiter: directed scenarios followed by
// constrained-random traffic compared against a behavioural model.
`default_nettype none

module tb_rf_read_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*ADDR_W-1:0] addr = '0;
  logic                   stall = 1'b0;
  logic [NREQ-1:0]        gnt;
  logic [ADDR_W-1:0]      rf_sel;
  logic [DATA_W-1:0]      rf_data;
  logic [DATA_W-1:0]      rdata;
  logic [NREQ-1:0]        rvalid;

  logic [DATA_W-1:0]      rf [32];

  rf_read_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .stall(stall),
    .gnt(gnt), .rf_sel(rf_sel), .rf_data(rf_data), .rdata(rdata), .rvalid(rvalid)
  );

  assign rf_data = rf[rf_sel];

  always #5 clk = ~clk;

  // Behavioural model state
  int                m_ptr;
  logic [NREQ-1:0]   m_gnt;
  logic [NREQ-1:0]   m_rvalid;
  logic [ADDR_W-1:0] m_sel;
  logic [DATA_W-1:0] m_rdata;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [DATA_W-1:0] reg_value(int a);
`ifdef ZERO_REG_EN
    if (a == 31) return '0;
`endif
    return rf[a];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    logic [NREQ-1:0] elig;
    int win;
    if (reset) begin
      m_ptr = 0; m_gnt = '0; m_rvalid = '0; m_sel = '0; m_rdata = '0;
    end else begin
      elig = req & ~m_gnt;
      win  = -1;
      if (m_gnt != '0) m_rdata = reg_value(int'(m_sel));
      m_rvalid = m_gnt;
      if (!stall) begin
        for (int k = 0; k < NREQ; k++) begin
          if (win < 0 && elig[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
        end
      end
      if (win >= 0) begin
        m_gnt = NREQ'(1) << win;
        m_sel = addr[win*ADDR_W +: ADDR_W];
        m_ptr = (win + 1) % NREQ;
      end else begin
        m_gnt = '0;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("gnt",    64'(gnt),    64'(m_gnt));
    chk("rf_sel", 64'(rf_sel), 64'(m_sel));
    chk("rvalid", 64'(rvalid), 64'(m_rvalid));
    chk("rdata",  64'(rdata),  64'(m_rdata));
  endtask

  task automatic set_addr(input int i, input int a);
    addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; stall = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] zexp;
    for (int r = 0; r < 32; r++) rf[r] = $urandom;
    m_ptr = 0; m_gnt = '0; m_rvalid = '0; m_sel = '0; m_rdata = '0;

    // Reset then idle
    reset = 1'b1;
    step(); step();
    chk("reset_gnt", 64'(gnt), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) step();
    chk("idle_rf_sel", 64'(rf_sel), 64'd0);
    chk("idle_rvalid", 64'(rvalid), 64'd0);

    // Single read
    rf[5] = 32'h0000_00A5;
    req = 4'b0100; set_addr(2, 5);
    step();
    chk("single_gnt", 64'(gnt), 64'h4);
    chk("single_sel", 64'(rf_sel), 64'd5);
    req = '0;
    step();
    chk("single_rvalid", 64'(rvalid), 64'h4);
    chk("single_rdata", 64'(rdata), 64'hA5);
    step();

    // Round robin from reset with all requesters active
    do_reset();
    for (int i = 0; i < NREQ; i++) set_addr(i, i + 1);
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("rr_order", 64'(gnt), 64'(1 << (c % 4)));
      if (c >= 1) chk("rr_data", 64'(rdata), 64'(rf[c]));
    end
    req = '0;
    step(); step();

    // Request raised together with stall
    do_reset();
    req = 4'b0010; set_addr(1, 9); stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_gnt", 64'(gnt), 64'd0);
    end
    stall = 1'b0;
    step();
    chk("unstall_gnt", 64'(gnt), 64'h2);
    req = '0;
    step();
    chk("unstall_rvalid", 64'(rvalid), 64'h2);
    chk("unstall_rdata", 64'(rdata), 64'(rf[9]));

    // Register 31
    rf[31] = 32'hDEAD_BEEF;
    req = 4'b0001; set_addr(0, 31);
    step();
    req = '0;
    step();
`ifdef ZERO_REG_EN
    zexp = '0;
`else
    zexp = 32'hDEAD_BEEF;
`endif
    chk("reg31_rdata", 64'(rdata), 64'(zexp));
    chk("reg31_rvalid", 64'(rvalid), 64'h1);

    // Reset while a grant is in flight
    do_reset();
    req = 4'b1000; set_addr(3, 7);
    step();
    chk("mid_gnt", 64'(gnt), 64'h8);
    reset = 1'b1; req = '0;
    step();
    chk("mid_rvalid", 64'(rvalid), 64'd0);
    chk("mid_rdata", 64'(rdata), 64'd0);
    reset = 1'b0; req = 4'b1111;
    step();
    chk("mid_ptr", 64'(gnt), 64'h1);
    req = '0;
    step(); step();

    // Random traffic obeying the requester handshake
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 4) == 0);
      rf[$urandom_range(0, 31)] = $urandom;
      for (int i = 0; i < NREQ; i++) begin
        if (!(req[i] && !m_gnt[i]) || m_rvalid == '1) begin
          req[i] = $urandom_range(0, 1) == 1;
          set_addr(i, $urandom_range(0, 31));
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_read_arbiter.md
# rf_read_arbiter

- Round-robin arbiter and sequencer for one read port of the 32-entry × 32-bit register file.
- Collects read requests from up to NREQ requesters (e.g. decode operand A/B, debug port, exception unit) and picks at most one per cycle.
- Drives the register-file read-mux select with the winner's address.
- Captures the mux output and returns it to the winner with a valid pulse, so several clients share one 32:1 read path.

## Interface
- NREQ, 4: number of requesters (2..8).
- DATA_W, 32: register width.
- ADDR_W, 5: register address width (32 registers).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester read request, level.
- addr  in  NREQ*ADDR_W  packed request addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- stall  in  1  when high, no new grant is issued.
- gnt  out  NREQ  registered one-hot grant pulse.
- rf_sel  out  ADDR_W  registered select to the register-file read mux.
- rf_data  in  DATA_W  read-mux output; combinational from rf_sel.
- rdata  out  DATA_W  registered read data.
- rvalid  out  NREQ  registered one-hot pulse; marks rdata as valid for requester i.

## Operation
- **Reset values:** gnt=0, rvalid=0, rdata=0, rf_sel=0, priority pointer=0 (requester 0 highest).
- **Eligible set:** req & ~gnt. A requester granted in the current cycle cannot win the arbitration made in that same cycle.
- **Arbitration:** each cycle with stall=0 and a non-empty eligible set:
  - the winner is the first eligible index at or after the pointer, searching upward and wrapping NREQ-1→0;
  - on the edge: gnt ← onehot(winner), rf_sel ← addr[winner], pointer ← (winner+1) mod NREQ.
- **Idle:** if stall=1 or the eligible set is empty, then on the edge gnt ← 0, and rf_sel and the pointer hold.
- **Capture:** on every edge, rdata ← rf_data if gnt≠0, otherwise rdata holds. rvalid ← gnt.
- **Requester rules:**
  - hold req and addr stable until gnt[i] is seen;
  - req may remain high in the gnt cycle;
  - drop req or issue a new request on the following edge.
- **Throughput:** one grant per cycle across requesters; at most one grant every 2 cycles to the same requester.
- **stall:** does not affect a grant already issued; its rvalid still fires.
- **addr width:** values are used unmodified; no range check is needed, since ADDR_W covers all 32 registers.

## Timing
- Edge E0 samples req → gnt[i] and rf_sel valid in cycle E0+1 → rdata and rvalid[i] valid in cycle E0+2.
- Latency: 2 cycles from the sampling edge to rvalid.
- Back-to-back grants pipeline. rdata changes every cycle under continuous load.
- **All requesters active:** grant order 0,1,2,3,0,… from reset.
- **Simultaneous req and stall rise:** no grant. The request stays pending.
- **Reset mid-operation:** in-flight gnt and rvalid are discarded, and the affected requesters receive no data. They must re-request.

## Configuration
- **ZERO_REG_EN defined:** a grant whose rf_sel = 31 captures rdata ← 0 regardless of rf_data. This gives an architectural zero register; grant and rvalid timing are unchanged.
- **ZERO_REG_EN undefined:** address 31 returns rf_data like any other register.

## Test plan
- Reset then idle: assert reset 2 cycles, release, req=0 → gnt, rvalid, rdata and rf_sel stay 0 for 10 cycles.
- Single read: rf holds r5=0x0000_00A5; req[2]=1, addr2=5 at E0 → gnt=4'b0100 and rf_sel=5 in E0+1; rvalid=4'b0100 and rdata=0xA5 in E0+2.
- Round robin: req=4'b1111 held, addr_i=i+1 → grants 0,1,2,3,0 on consecutive cycles. Each requester is granted only every 4 cycles, and rdata follows r1,r2,r3,r4.
- Stall: req[1]=1 with stall=1 for 3 cycles → no gnt. Stall drops → gnt[1] on the next cycle, rvalid[1] one cycle later.
- Zero register: r31=0xDEAD_BEEF, req[0]=1, addr0=31 →
  - rdata=0 with ZERO_REG_EN defined;
  - rdata=0xDEAD_BEEF without it.
- Reset mid-read: reset asserted in the cycle gnt[3]=1 → the next cycle has rvalid=0 and rdata=0, and the pointer returns to 0.
